// File: rtl/address_decoder_driver.sv
// Registered 4-bit address to 15-line one-hot select driver.
// Each accepted address drives its select line for HOLD_CYCLES, then all
// selects stay low for GAP_CYCLES before the next address can be taken.
// When no external request is pending, auto-scan can launch addresses 0..14 in turn.
module address_decoder_driver #(
  parameter int unsigned HOLD_CYCLES = 4,
  parameter int unsigned GAP_CYCLES  = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  AddrIn,
  input  logic        AddrValid,
  input  logic        ScanEn,
  output logic        AddrReady,
  output logic [14:0] SelOut,
  output logic        SelActive,
  output logic [3:0]  CurAddr,
  output logic        AddrErr,
  output logic        Done
);

  localparam int unsigned CntMax = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int unsigned CntW   = $clog2(CntMax + 1);
  localparam logic [CntW-1:0] HoldLoad = CntW'(HOLD_CYCLES - 1);
  localparam logic [CntW-1:0] GapLoad  = CntW'(GAP_CYCLES - 1);
  localparam logic [CntW-1:0] CntOne   = CntW'(1);

  typedef enum logic [1:0] {StIdle, StHold, StGap} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [3:0]      cur_addr_q, cur_addr_d;
  logic [3:0]      scan_addr_q, scan_addr_d;
  logic [14:0]     sel_q, sel_d;
  logic            sel_active_q, sel_active_d;
  logic            ready_q, ready_d;
  logic            err_q, err_d;
  logic            done_q, done_d;
  logic            launch;
  logic [3:0]      launch_addr;

  // Address 0 maps to the top line; 1..14 map to lines 0..13; 15 maps to nothing.
  function automatic logic [14:0] decode(input logic [3:0] addr);
    logic [14:0] sel;
    sel = '0;
    if (addr == 4'd0) begin
      sel[14] = 1'b1;
    end else if (addr != 4'hF) begin
      sel[addr - 4'd1] = 1'b1;
    end
    return sel;
  endfunction

  // Next-state logic: handshake/scan launch, hold and gap countdowns.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    cur_addr_d   = cur_addr_q;
    scan_addr_d  = scan_addr_q;
    sel_d        = sel_q;
    sel_active_d = sel_active_q;
    ready_d      = ready_q;
    err_d        = 1'b0;
    done_d       = 1'b0;
    launch       = 1'b0;
    launch_addr  = scan_addr_q;

    case (state_q)
      StIdle: begin
        if (AddrValid) begin
          // External request wins over scan; the scan pointer does not move.
          if (AddrIn == 4'hF) begin
            err_d = 1'b1;
          end else begin
            launch      = 1'b1;
            launch_addr = AddrIn;
          end
        end else if (ScanEn) begin
          launch      = 1'b1;
          launch_addr = scan_addr_q;
          scan_addr_d = (scan_addr_q == 4'd14) ? 4'd0 : scan_addr_q + 4'd1;
        end
      end
      StHold: begin
        if (cnt_q == '0) begin
          state_d      = StGap;
          cnt_d        = GapLoad;
          sel_d        = '0;
          sel_active_d = 1'b0;
          // A single-cycle gap is also the last gap cycle.
          done_d       = (GapLoad == '0);
        end else begin
          cnt_d = cnt_q - CntOne;
        end
      end
      StGap: begin
        if (cnt_q == '0) begin
          state_d = StIdle;
          ready_d = 1'b1;
        end else begin
          cnt_d  = cnt_q - CntOne;
          done_d = (cnt_q == CntOne);
        end
      end
      default: begin
        state_d      = StIdle;
        cnt_d        = '0;
        sel_d        = '0;
        sel_active_d = 1'b0;
        ready_d      = 1'b1;
      end
    endcase

    if (launch) begin
      state_d      = StHold;
      cnt_d        = HoldLoad;
      cur_addr_d   = launch_addr;
      sel_d        = decode(launch_addr);
      sel_active_d = 1'b1;
      ready_d      = 1'b0;
    end
  end

  // State and output registers; reset clears the select bus without a clock edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      cur_addr_q   <= 4'd0;
      scan_addr_q  <= 4'd0;
      sel_q        <= '0;
      sel_active_q <= 1'b0;
      ready_q      <= 1'b1;
      err_q        <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      cur_addr_q   <= cur_addr_d;
      scan_addr_q  <= scan_addr_d;
      sel_q        <= sel_d;
      sel_active_q <= sel_active_d;
      ready_q      <= ready_d;
      err_q        <= err_d;
      done_q       <= done_d;
    end
  end

  assign AddrReady = ready_q;
  assign SelOut    = sel_q;
  assign SelActive = sel_active_q;
  assign CurAddr   = cur_addr_q;
  assign AddrErr   = err_q;
  assign Done      = done_q;

endmodule

// File: tb/tb_address_decoder_driver.sv
// Scoreboard bench for address_decoder_driver: a cycle-count model predicts
// handshake timing, and a queue of expected strobes/errors is checked by a
// separate monitor as the DUT presents them.
module tb_address_decoder_driver;

  localparam int H = 4;
  localparam int G = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  AddrIn = 4'd0;
  logic        AddrValid = 1'b0;
  logic        ScanEn = 1'b0;
  logic        AddrReady;
  logic [14:0] SelOut;
  logic        SelActive;
  logic [3:0]  CurAddr;
  logic        AddrErr;
  logic        Done;

  address_decoder_driver #(
    .HOLD_CYCLES(H),
    .GAP_CYCLES (G)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .AddrIn   (AddrIn),
    .AddrValid(AddrValid),
    .ScanEn   (ScanEn),
    .AddrReady(AddrReady),
    .SelOut   (SelOut),
    .SelActive(SelActive),
    .CurAddr  (CurAddr),
    .AddrErr  (AddrErr),
    .Done     (Done)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit err;
    int addr;
  } exp_t;

  exp_t q[$];
  int   cmps = 0;
  int   errs = 0;

  // Reference model state: busy counts remaining non-ready cycles of a strobe.
  int   busy = 0;
  int   scan = 0;
  int   cur  = 0;
  bit   err_f = 0;
  bit   took_req = 0;

  function automatic logic [14:0] dec(input int a);
    logic [14:0] one;
    one = 15'd1;
    if (a == 0) return 15'h4000;
    return one << (a - 1);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    cmps++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Reference model: one launch per ready cycle, strobe occupies H+G cycles.
  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        busy = 0; scan = 0; cur = 0; err_f = 0; took_req = 0;
        q.delete();
      end else begin
        err_f = 0;
        took_req = 0;
        if (busy == 0) begin
          if (AddrValid) begin
            took_req = 1;
            if (AddrIn == 4'hF) begin
              err_f = 1;
              q.push_back('{err: 1'b1, addr: 15});
            end else begin
              cur  = int'(AddrIn);
              busy = H + G;
              q.push_back('{err: 1'b0, addr: int'(AddrIn)});
            end
          end else if (ScanEn) begin
            cur  = scan;
            busy = H + G;
            q.push_back('{err: 1'b0, addr: scan});
            scan = (scan + 1) % 15;
          end
        end else begin
          busy--;
        end
      end
    end
  end

  // Monitor: per-cycle timing checks plus scoreboard pops on strobe start / error pulse.
  initial begin
    logic [14:0] prev_sel;
    exp_t e;
    prev_sel = '0;
    forever begin
      @(negedge clk);
      chk("ready", 32'(AddrReady), 32'(busy == 0));
      chk("sel_active", 32'(SelActive), 32'(busy > G));
      chk("sel_nonzero", 32'(SelOut != 15'd0), 32'(busy > G));
      chk("done", 32'(Done), 32'(busy == 1));
      chk("addr_err", 32'(AddrErr), 32'(err_f));
      chk("cur_addr", 32'(CurAddr), 32'(cur));
      if (SelOut != 15'd0 && prev_sel == 15'd0) begin
        if (q.size() == 0) begin
          cmps++; errs++;
          $display("FAIL strobe_unexpected: got %0h expected none", SelOut);
        end else begin
          e = q.pop_front();
          chk("strobe_kind", 32'(0), 32'(e.err));
          chk("strobe_sel", 32'(SelOut), 32'(dec(e.addr)));
          chk("strobe_addr", 32'(CurAddr), 32'(e.addr));
        end
      end
      if (AddrErr) begin
        if (q.size() == 0) begin
          cmps++; errs++;
          $display("FAIL err_unexpected: got 1 expected none");
        end else begin
          e = q.pop_front();
          chk("err_kind", 32'(1), 32'(e.err));
        end
      end
      prev_sel = SelOut;
    end
  end

  // Present an address and keep AddrValid high until the handshake is taken.
  task automatic send(input logic [3:0] a, input bit scramble);
    int n;
    n = 0;
    AddrValid = 1'b1;
    forever begin
      if (scramble && busy != 0) AddrIn = 4'($urandom);
      else AddrIn = a;
      @(posedge clk); #1;
      if (took_req) break;
      n++;
      if (n > 50) begin
        chk("handshake_timeout", 32'(0), 32'(1));
        break;
      end
    end
    AddrValid = 1'b0;
    AddrIn = 4'($urandom);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy != 0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 100) chk("idle_timeout", 32'(0), 32'(1));
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #3 rst = 1'b0;
    cycles(1);

    // Directed decodes.
    send(4'd0, 0); wait_idle(); cycles(1);
    send(4'd5, 0); send(4'd14, 0); send(4'd1, 0); wait_idle();

    // Illegal address followed at once by a legal one, then back-to-back illegals.
    send(4'd15, 0); send(4'd3, 0); wait_idle();
    send(4'd15, 0); send(4'd15, 0); send(4'd15, 0); cycles(2);

    // Continuous scan through a full wrap, then an interrupting request.
    ScanEn = 1'b1;
    cycles(16 * (1 + H + G));
    send(4'd7, 0);
    cycles(20);
    ScanEn = 1'b0;
    wait_idle();

    // Changing AddrIn while not ready must be ignored.
    send(4'd10, 1); send(4'd2, 1); send(4'd15, 1); send(4'd12, 1); wait_idle();

    // Asynchronous reset in the second hold cycle of address 9.
    send(4'd9, 0);
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    chk("rst_sel", 32'(SelOut), 32'(0));
    chk("rst_cur", 32'(CurAddr), 32'(0));
    chk("rst_ready", 32'(AddrReady), 32'(1));
    @(posedge clk); #3;
    rst = 1'b0;
    cycles(1);
    send(4'd6, 0); wait_idle();

    // Random mix of requests, illegal addresses, scan and idle periods.
    for (int i = 0; i < 300; i++) begin
      ScanEn = 1'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        send(4'($urandom), 1'($urandom));
      end else begin
        cycles($urandom_range(1, 4));
      end
    end
    ScanEn = 1'b0;
    wait_idle();
    cycles(3);
    chk("queue_empty", 32'(q.size()), 32'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, errs);
    $finish;
  end

endmodule
